// File: rtl/axi_pkg.sv
// Shared AXI read types, cache attributes and the 4 KB boundary helper
// used by the burst read master and its burst-length calculator.
package axi_pkg;

  typedef enum logic [2:0] {
    SIZE_1   = 3'd0,
    SIZE_2   = 3'd1,
    SIZE_4   = 3'd2,
    SIZE_8   = 3'd3,
    SIZE_16  = 3'd4,
    SIZE_32  = 3'd5,
    SIZE_64  = 3'd6,
    SIZE_128 = 3'd7
  } AxiSize_t;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } AxiBurst_t;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } AxiResp_t;

  // Bit order follows the AxCACHE encoding: bit 0 is Bufferable.
  typedef struct packed {
    logic allocate;
    logic otherAllocate;
    logic modifiable;
    logic bufferable;
  } AxiCache_t;

  typedef struct packed {
    logic [31:0] address;
    logic [15:0] bytes;
  } AxiMasterRdCtrl_t;

  typedef struct packed {
    AxiResp_t resp;
  } AxiMasterRdStatus_t;

  localparam AxiCache_t CACHE_BUFFERABLE = '{allocate: 1'b0, otherAllocate: 1'b0,
                                             modifiable: 1'b0, bufferable: 1'b1};

  // Number of beats of 2**sizeLog2 bytes left before the next 4 KB page.
  function automatic logic [12:0] beatsTo4k(input logic [31:0] addr, input int sizeLog2);
    logic [12:0] bytesLeft;
    bytesLeft = 13'd4096 - {1'b0, addr[11:0]};
    return bytesLeft >> sizeLog2;
  endfunction

endpackage

// File: rtl/axi_rd_burst_master_calc.sv
// Combinational burst sizing: the largest burst that fits the remaining
// beats, the burst length cap and the current 4 KB page.
module axi_burst_calc
  import axi_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic [31:0] addr_i,
  input  logic [15:0] remaining_i,
  output logic [8:0]  beats_o
);

  localparam int SIZE_LOG2 = $clog2(DATA_W / 8);
  localparam logic [16:0] MAX_LEN = 17'(MAX_BURST_LEN);

  logic [16:0] toBoundary;
  logic [16:0] remWide;

  // Minimum of the three limits; every winning branch fits in 9 bits.
  always_comb begin
    toBoundary = {4'd0, beatsTo4k(addr_i, SIZE_LOG2)};
    remWide    = {1'b0, remaining_i};
    if (MAX_LEN <= remWide && MAX_LEN <= toBoundary) begin
      beats_o = 9'(MAX_BURST_LEN);
    end else if (toBoundary <= remWide) begin
      beats_o = toBoundary[8:0];
    end else begin
      beats_o = remWide[8:0];
    end
  end

endmodule

// File: rtl/axi_rd_burst_master.sv
// AXI4 read burst master: splits one byte-count request into 4 KB-safe
// INCR bursts, limits bursts in flight and streams R data to a consumer.
module axi_rd_burst_master
  import axi_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int MAX_BURST_LEN   = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ctrl_valid,
  output logic               ctrl_ready,
  input  AxiMasterRdCtrl_t   ctrl,
  output logic               status_valid,
  output AxiMasterRdStatus_t status,
  output logic [31:0]        araddr,
  output logic [7:0]         arlen,
  output AxiSize_t           arsize,
  output AxiBurst_t          arburst,
  output AxiCache_t          arcache,
  output logic               arvalid,
  input  logic               arready,
  input  logic [DATA_W-1:0]  rdata,
  input  AxiResp_t           rresp,
  input  logic               rlast,
  input  logic               rvalid,
  output logic               rready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int BYTES     = DATA_W / 8;
  localparam int SIZE_LOG2 = $clog2(BYTES);
  localparam int OUT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);
  localparam logic [31:0] ALIGN_MASK = 32'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t         state_q, state_d;
  logic [15:0]    remaining_q, remaining_d;
  logic [31:0]    nextAddr_q, nextAddr_d;
  logic [31:0]    araddr_q, araddr_d;
  logic [7:0]     arlen_q, arlen_d;
  logic           arvalid_q, arvalid_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  AxiResp_t       resp_q, resp_d;
  logic           statusValid_q, statusValid_d;

  logic        arHs;
  logic        rActive;
  logic        lastHs;
  logic        misaligned;
  logic [31:0] burstBytes;
  logic [8:0]  calcBeats;

  assign arHs       = arvalid_q && arready;
  assign rActive    = (outstanding_q != '0);
  assign lastHs     = rvalid && out_ready && rActive && rlast;
  assign misaligned = (|(ctrl.address & ALIGN_MASK)) || (|(ctrl.bytes & ALIGN_MASK[15:0]));
  assign burstBytes = (32'(arlen_q) + 32'd1) << SIZE_LOG2;

  assign ctrl_ready   = (state_q == IDLE);
  assign status_valid = statusValid_q;
  assign status.resp  = resp_q;
  assign araddr       = araddr_q;
  assign arlen        = arlen_q;
  assign arvalid      = arvalid_q;
  assign arsize       = AxiSize_t'(3'(SIZE_LOG2));
  assign arburst      = INCR;
  assign arcache      = CACHE_BUFFERABLE;
  assign rready       = out_ready;
  assign out_valid    = rvalid && rActive;
  assign out_data     = rdata;
  assign out_last     = rlast && rActive && (state_q == DRAIN) && (outstanding_q == OUT_ONE);

  axi_burst_calc #(
    .DATA_W        (DATA_W),
    .MAX_BURST_LEN (MAX_BURST_LEN)
  ) u_calc (
    .addr_i      (nextAddr_d),
    .remaining_i (remaining_d),
    .beats_o     (calcBeats)
  );

  // Transfer sequencing, beat/address bookkeeping and sticky response.
  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    nextAddr_d    = nextAddr_q;
    resp_d        = resp_q;
    statusValid_d = 1'b0;
    outstanding_d = outstanding_q;
    if (arHs && !lastHs) begin
      outstanding_d = outstanding_q + OUT_ONE;
    end else if (!arHs && lastHs) begin
      outstanding_d = outstanding_q - OUT_ONE;
    end
    case (state_q)
      IDLE: begin
        if (ctrl_valid) begin
          resp_d = OKAY;
          if (misaligned) begin
            resp_d  = SLVERR;
            state_d = DONE;
          end else if (ctrl.bytes == 16'd0) begin
            state_d = DONE;
          end else begin
            state_d     = ISSUE;
            remaining_d = ctrl.bytes >> SIZE_LOG2;
            nextAddr_d  = ctrl.address;
          end
        end
      end
      ISSUE: begin
        if (arHs) begin
          remaining_d = remaining_q - (16'(arlen_q) + 16'd1);
          nextAddr_d  = nextAddr_q + burstBytes;
          if (remaining_d == 16'd0) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (outstanding_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        statusValid_d = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if ((state_q == ISSUE || state_q == DRAIN) && lastHs == lastHs && rvalid && out_ready && rActive
        && resp_q == OKAY && (rresp == SLVERR || rresp == DECERR)) begin
      resp_d = rresp;
    end
  end

  // AR channel: hold a stalled request, otherwise launch the next burst
  // whenever the outstanding limit leaves room.
  always_comb begin
    arvalid_d = 1'b0;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    if (arvalid_q && !arready) begin
      arvalid_d = 1'b1;
    end else if (state_d == ISSUE && outstanding_d != OUT_MAX) begin
      arvalid_d = 1'b1;
      araddr_d  = nextAddr_d;
      arlen_d   = 8'(calcBeats - 9'd1);
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      remaining_q   <= '0;
      nextAddr_q    <= '0;
      araddr_q      <= '0;
      arlen_q       <= '0;
      arvalid_q     <= 1'b0;
      outstanding_q <= '0;
      resp_q        <= OKAY;
      statusValid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      nextAddr_q    <= nextAddr_d;
      araddr_q      <= araddr_d;
      arlen_q       <= arlen_d;
      arvalid_q     <= arvalid_d;
      outstanding_q <= outstanding_d;
      resp_q        <= resp_d;
      statusValid_q <= statusValid_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_burst_master.sv
// Directed bench for axi_rd_burst_master with a small AXI read slave model.
module tb_axi_rd_burst_master;
  import axi_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               ctrl_valid;
  logic               ctrl_ready;
  AxiMasterRdCtrl_t   ctrl;
  logic               status_valid;
  AxiMasterRdStatus_t status;
  logic [31:0]        araddr;
  logic [7:0]         arlen;
  AxiSize_t           arsize;
  AxiBurst_t          arburst;
  AxiCache_t          arcache;
  logic               arvalid;
  logic               arready;
  logic [31:0]        rdata;
  AxiResp_t           rresp;
  logic               rlast;
  logic               rvalid;
  logic               rready;
  logic [31:0]        out_data;
  logic               out_last;
  logic               out_valid;
  logic               out_ready;

  axi_rd_burst_master #(
    .DATA_W          (32),
    .MAX_BURST_LEN   (16),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ctrl_valid   (ctrl_valid),
    .ctrl_ready   (ctrl_ready),
    .ctrl         (ctrl),
    .status_valid (status_valid),
    .status       (status),
    .araddr       (araddr),
    .arlen        (arlen),
    .arsize       (arsize),
    .arburst      (arburst),
    .arcache      (arcache),
    .arvalid      (arvalid),
    .arready      (arready),
    .rdata        (rdata),
    .rresp        (rresp),
    .rlast        (rlast),
    .rvalid       (rvalid),
    .rready       (rready),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // Slave model state and observation counters
  int          rDelay = 0;
  int          errBeat = -1;
  logic        toggleReady = 1'b0;
  logic [7:0]  arQ[$];
  logic [31:0] arAddrLog[$];
  logic [7:0]  arLenLog[$];
  int arCount = 0, outsModel = 0, maxOuts = 0, capViolations = 0;
  int arvalidCycles = 0, rreadyBad = 0, readyLowCycles = 0;
  int statusCount = 0, statusCyc = 0, hsCyc = 0;
  int beatsOut = 0, lastCount = 0, lastAt = 0, genBeat = 0;
  AxiResp_t statusResp = OKAY;
  logic rActiveB = 1'b0;
  int beatInBurst = 0, waitCnt = 0;
  logic [7:0] burstLen = 8'd0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Read slave: sample at negedge, update drivers just after posedge
  initial begin : slave
    logic arHsS, rHsS, rLastS;
    logic [31:0] arAddrS;
    logic [7:0] arLenS;
    rvalid = 1'b0; rdata = '0; rresp = OKAY; rlast = 1'b0; out_ready = 1'b1;
    forever begin
      @(negedge clk);
      arHsS = arvalid && arready; arAddrS = araddr; arLenS = arlen;
      rHsS = rvalid && rready; rLastS = rlast;
      if (arvalid) arvalidCycles++;
      if (arvalid && outsModel >= 4) capViolations++;
      if (rready !== out_ready) rreadyBad++;
      if (!out_ready) readyLowCycles++;
      if (status_valid) begin
        statusCount++; statusResp = status.resp; statusCyc = cyc;
      end
      if (out_valid && out_ready) begin
        beatsOut++;
        checkOutput("beat_data", out_data, genBeat);
        if (out_last) begin lastCount++; lastAt = beatsOut; end
      end
      @(posedge clk); #1;
      if (arHsS) begin
        arQ.push_back(arLenS); arAddrLog.push_back(arAddrS); arLenLog.push_back(arLenS);
        arCount++; outsModel++;
        if (outsModel > maxOuts) maxOuts = outsModel;
      end
      if (rHsS) begin
        genBeat++;
        if (rLastS) begin rActiveB = 1'b0; outsModel--; end
        else beatInBurst++;
      end
      if (!rActiveB && arQ.size() != 0) begin
        if (waitCnt < rDelay) waitCnt++;
        else begin
          waitCnt = 0; rActiveB = 1'b1; burstLen = arQ.pop_front(); beatInBurst = 0;
        end
      end
      if (toggleReady) out_ready = !out_ready; else out_ready = 1'b1;
      rvalid = rActiveB;
      rdata  = genBeat;
      rlast  = rActiveB && (beatInBurst == int'(burstLen));
      rresp  = (genBeat == errBeat) ? SLVERR : OKAY;
    end
  end

  task automatic applyStimulus(input logic [31:0] addr, input logic [15:0] nbytes);
    int budget = 50;
    logic got = 1'b0;
    @(posedge clk); #1;
    ctrl_valid = 1'b1; ctrl.address = addr; ctrl.bytes = nbytes;
    while (!got && budget > 0) begin
      @(negedge clk);
      if (ctrl_ready) begin got = 1'b1; hsCyc = cyc; end
      budget--;
    end
    @(posedge clk); #1;
    ctrl_valid = 1'b0;
    checkOutput("ctrl_handshake", got, 1);
  endtask

  task automatic waitStatus(input int s0, input int budget);
    int left = budget;
    while (statusCount == s0 && left > 0) begin
      @(posedge clk); left--;
    end
    checkOutput("status_seen", statusCount - s0, 1);
  endtask

  initial begin : main
    int ar0, b0, l0, s0, v0, left;
    rst_n = 1'b0; ctrl_valid = 1'b0; ctrl = '0; arready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_ctrl_ready", ctrl_ready, 1);
    checkOutput("rst_arvalid", arvalid, 0);
    checkOutput("rst_status_valid", status_valid, 0);
    checkOutput("rst_araddr", araddr, 0);
    checkOutput("rst_arlen", arlen, 0);
    checkOutput("rst_out_valid", out_valid, 0);

    // Single aligned 16-beat burst
    ar0 = arCount; b0 = beatsOut; l0 = lastCount; s0 = statusCount;
    applyStimulus(32'h1000, 16'd64);
    waitStatus(s0, 500);
    checkOutput("t1_ar_count", arCount - ar0, 1);
    checkOutput("t1_araddr", arAddrLog[ar0], 32'h1000);
    checkOutput("t1_arlen", arLenLog[ar0], 15);
    checkOutput("t1_arsize", arsize, SIZE_4);
    checkOutput("t1_arburst", arburst, INCR);
    checkOutput("t1_arcache", arcache, 4'b0001);
    checkOutput("t1_beats", beatsOut - b0, 16);
    checkOutput("t1_last_count", lastCount - l0, 1);
    checkOutput("t1_last_pos", lastAt - b0, 16);
    checkOutput("t1_resp", statusResp, OKAY);

    // Transfer straddling a 4 KB page
    ar0 = arCount; b0 = beatsOut; s0 = statusCount;
    applyStimulus(32'h0FF0, 16'd32);
    waitStatus(s0, 500);
    checkOutput("t2_ar_count", arCount - ar0, 2);
    checkOutput("t2_araddr0", arAddrLog[ar0], 32'h0FF0);
    checkOutput("t2_arlen0", arLenLog[ar0], 3);
    checkOutput("t2_araddr1", arAddrLog[ar0+1], 32'h1000);
    checkOutput("t2_arlen1", arLenLog[ar0+1], 3);
    checkOutput("t2_beats", beatsOut - b0, 8);

    // Long transfer with slow R: outstanding limit must engage
    rDelay = 20; maxOuts = 0;
    ar0 = arCount; b0 = beatsOut; l0 = lastCount; s0 = statusCount;
    applyStimulus(32'h1000, 16'd384);
    waitStatus(s0, 3000);
    rDelay = 0;
    checkOutput("t3_ar_count", arCount - ar0, 6);
    checkOutput("t3_max_outstanding", maxOuts, 4);
    checkOutput("t3_cap_violations", capViolations, 0);
    checkOutput("t3_araddr5", arAddrLog[ar0+5], 32'h1140);
    checkOutput("t3_beats", beatsOut - b0, 96);
    checkOutput("t3_last_pos", lastAt - b0, 96);
    checkOutput("t3_last_count", lastCount - l0, 1);
    checkOutput("t3_resp", statusResp, OKAY);

    // Misaligned address: error without any AR
    v0 = arvalidCycles; s0 = statusCount;
    applyStimulus(32'h1002, 16'd8);
    waitStatus(s0, 50);
    checkOutput("t4_no_arvalid", arvalidCycles - v0, 0);
    checkOutput("t4_status_delay", statusCyc - hsCyc, 2);
    checkOutput("t4_resp", statusResp, SLVERR);

    // Zero-length request
    v0 = arvalidCycles; s0 = statusCount;
    applyStimulus(32'h4000, 16'd0);
    waitStatus(s0, 50);
    checkOutput("t4z_no_arvalid", arvalidCycles - v0, 0);
    checkOutput("t4z_resp", statusResp, OKAY);

    // Error on beat 5 with a stalling consumer
    errBeat = genBeat + 4; toggleReady = 1'b1;
    b0 = beatsOut; s0 = statusCount; v0 = readyLowCycles;
    applyStimulus(32'h2000, 16'd64);
    waitStatus(s0, 500);
    toggleReady = 1'b0; errBeat = -1;
    checkOutput("t5_beats", beatsOut - b0, 16);
    checkOutput("t5_rready_tracks", rreadyBad, 0);
    checkOutput("t5_stalled", (readyLowCycles - v0) > 0, 1);
    checkOutput("t5_resp", statusResp, SLVERR);

    // Reset while draining
    rDelay = 30;
    ar0 = arCount; b0 = beatsOut; s0 = statusCount;
    applyStimulus(32'h3000, 16'd64);
    left = 100;
    while (arCount == ar0 && left > 0) begin @(posedge clk); left--; end
    checkOutput("t6_ar_seen", arCount - ar0, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("t6_drain_ctrl_ready", ctrl_ready, 0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t6_rst_arvalid", arvalid, 0);
    checkOutput("t6_rst_status_valid", status_valid, 0);
    checkOutput("t6_rst_ctrl_ready", ctrl_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    left = 300;
    while ((arQ.size() != 0 || rActiveB) && left > 0) begin @(posedge clk); left--; end
    repeat (3) @(posedge clk);
    rDelay = 0;
    checkOutput("t6_stray_beats", beatsOut - b0, 0);
    checkOutput("t6_no_status", statusCount - s0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
